// File: rtl/mc_control_unit.sv
// Multicycle MIPS main control FSM.
// Sequences FETCH / DECODE / execute / writeback for lw, sw, R-type, beq,
// addi and j, and drives the datapath enables and mux selects for each step.
// The outputs are a Moore decode of the state register. The exceptions are
// PCEn_o, which looks at zero_i in BRANCH, and illegal_o, which looks at
// opcode_i in DECODE.
// Optional feature macro: MC_CU_BNE_EN adds bne (opcode 000101) support.
//
// Handshake note: this block has no valid/ready channels. The instruction
// register must hold opcode_i stable from DECODE until the instruction
// returns to FETCH. zero_i only needs to be valid during BRANCH.
module mc_control_unit #(
  parameter int OPW = 6,
  parameter int STW = 4
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [OPW-1:0] opcode_i,
  input  logic           zero_i,
  output logic           IorD_o,
  output logic           MemWrite_o,
  output logic           IRWrite_o,
  output logic           RegDst_o,
  output logic           MemtoReg_o,
  output logic           RegWrite_o,
  output logic           ALUSrcA_o,
  output logic [1:0]     ALUSrcB_o,
  output logic [1:0]     ALUOp_o,
  output logic [1:0]     PCSrc_o,
  output logic           PCEn_o,
  output logic           illegal_o,
  output logic [STW-1:0] state_o
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_BRANCH = 4'd8,
    S_ADDIEX = 4'd9,
    S_ADDIWB = 4'd10,
    S_JUMP   = 4'd11
  } state_t;

  localparam logic [OPW-1:0] OP_LW   = OPW'(6'b100011);
  localparam logic [OPW-1:0] OP_SW   = OPW'(6'b101011);
  localparam logic [OPW-1:0] OP_R    = OPW'(6'b000000);
  localparam logic [OPW-1:0] OP_BEQ  = OPW'(6'b000100);
  localparam logic [OPW-1:0] OP_ADDI = OPW'(6'b001000);
  localparam logic [OPW-1:0] OP_J    = OPW'(6'b000010);
`ifdef MC_CU_BNE_EN
  localparam logic [OPW-1:0] OP_BNE  = OPW'(6'b000101);
`endif

  state_t state;
  state_t next_state;

  logic       iord;
  logic       mem_write;
  logic       ir_write;
  logic       reg_dst;
  logic       mem_to_reg;
  logic       reg_write;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] alu_op;
  logic [1:0] pc_src;
  logic       pc_en;
  logic       illegal;
  logic       branch_taken;

  // Branch condition: beq takes on zero. When bne is enabled, bne takes on non-zero.
`ifdef MC_CU_BNE_EN
  assign branch_taken = (opcode_i == OP_BNE) ? ~zero_i : zero_i;
`else
  assign branch_taken = zero_i;
`endif

  // Next-state selection: DECODE dispatches on the opcode, and every terminal step returns to FETCH.
  always_comb begin
    next_state = S_FETCH;
    case (state)
      S_FETCH:  next_state = S_DECODE;
      S_DECODE: begin
        if (opcode_i == OP_LW || opcode_i == OP_SW) next_state = S_MEMADR;
        else if (opcode_i == OP_R)                  next_state = S_EXEC;
        else if (opcode_i == OP_BEQ)                next_state = S_BRANCH;
`ifdef MC_CU_BNE_EN
        else if (opcode_i == OP_BNE)                next_state = S_BRANCH;
`endif
        else if (opcode_i == OP_ADDI)               next_state = S_ADDIEX;
        else if (opcode_i == OP_J)                  next_state = S_JUMP;
        else                                        next_state = S_FETCH;
      end
      S_MEMADR: next_state = (opcode_i == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:  next_state = S_MEMWB;
      S_EXEC:   next_state = S_ALUWB;
      S_ADDIEX: next_state = S_ADDIWB;
      default:  next_state = S_FETCH;
    endcase
  end

  // State register: an asynchronous reset aborts any instruction in flight and restarts at FETCH.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_FETCH;
    else        state <= next_state;
  end

  // Per-state control decode: anything a state does not set stays 0.
  always_comb begin
    iord       = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    reg_write  = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'b00;
    alu_op     = 2'b00;
    pc_src     = 2'b00;
    pc_en      = 1'b0;
    illegal    = 1'b0;
    case (state)
      S_FETCH: begin
        ir_write  = 1'b1;
        alu_src_b = 2'b01;
        pc_en     = 1'b1;
      end
      S_DECODE: begin
        alu_src_b = 2'b11;
        illegal   = (next_state == S_FETCH);
      end
      S_MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
      end
      S_MEMRD: iord = 1'b1;
      S_MEMWB: begin
        mem_to_reg = 1'b1;
        reg_write  = 1'b1;
      end
      S_MEMWR: begin
        iord      = 1'b1;
        mem_write = 1'b1;
      end
      S_EXEC: begin
        alu_src_a = 1'b1;
        alu_op    = 2'b10;
      end
      S_ALUWB: begin
        reg_dst   = 1'b1;
        reg_write = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a = 1'b1;
        alu_op    = 2'b01;
        pc_src    = 2'b01;
        pc_en     = branch_taken;
      end
      S_ADDIEX: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
      end
      S_ADDIWB: reg_write = 1'b1;
      S_JUMP: begin
        pc_src = 2'b10;
        pc_en  = 1'b1;
      end
      default: ;
    endcase
  end

  // While reset is held low, the write enables and the illegal pulse are forced off.
  // The mux selects keep showing their FETCH values.
  assign IorD_o     = iord;
  assign MemWrite_o = mem_write & reset;
  assign IRWrite_o  = ir_write & reset;
  assign RegDst_o   = reg_dst;
  assign MemtoReg_o = mem_to_reg;
  assign RegWrite_o = reg_write & reset;
  assign ALUSrcA_o  = alu_src_a;
  assign ALUSrcB_o  = alu_src_b;
  assign ALUOp_o    = alu_op;
  assign PCSrc_o    = pc_src;
  assign PCEn_o     = pc_en & reset;
  assign illegal_o  = illegal & reset;
  assign state_o    = STW'(state);

endmodule

// File: tb/tb_mc_control_unit.sv
// Bench for mc_control_unit: directed instructions, a mid-instruction reset, then random opcodes.
// Expected values come from a per-instruction step model.
module tb_mc_control_unit;

  logic       clk;
  logic       reset;
  logic [5:0] opcode_i;
  logic       zero_i;
  logic       IorD_o, MemWrite_o, IRWrite_o, RegDst_o, MemtoReg_o, RegWrite_o, ALUSrcA_o;
  logic [1:0] ALUSrcB_o, ALUOp_o, PCSrc_o;
  logic       PCEn_o, illegal_o;
  logic [3:0] state_o;

  int tests_run = 0;
  int tests_failed = 0;

`ifdef MC_CU_BNE_EN
  localparam bit BNE_EN = 1'b1;
`else
  localparam bit BNE_EN = 1'b0;
`endif

  typedef struct packed {
    logic       iord, memwrite, irwrite, regdst, memtoreg, regwrite, srca;
    logic [1:0] srcb, aluop, pcsrc;
    logic       pcen, illegal;
  } ctrl_t;

  mc_control_unit #(.OPW(6), .STW(4)) dut (
    .clk(clk), .reset(reset), .opcode_i(opcode_i), .zero_i(zero_i),
    .IorD_o(IorD_o), .MemWrite_o(MemWrite_o), .IRWrite_o(IRWrite_o),
    .RegDst_o(RegDst_o), .MemtoReg_o(MemtoReg_o), .RegWrite_o(RegWrite_o),
    .ALUSrcA_o(ALUSrcA_o), .ALUSrcB_o(ALUSrcB_o), .ALUOp_o(ALUOp_o),
    .PCSrc_o(PCSrc_o), .PCEn_o(PCEn_o), .illegal_o(illegal_o), .state_o(state_o)
  );

  // Clock: 10-time-unit period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic ctrl_t observed();
    ctrl_t c;
    c = {IorD_o, MemWrite_o, IRWrite_o, RegDst_o, MemtoReg_o, RegWrite_o, ALUSrcA_o,
         ALUSrcB_o, ALUOp_o, PCSrc_o, PCEn_o, illegal_o};
    return c;
  endfunction

  function automatic bit legal(input logic [5:0] op);
    return op == 6'b100011 || op == 6'b101011 || op == 6'b000000 || op == 6'b000100 ||
           op == 6'b001000 || op == 6'b000010 || (BNE_EN && op == 6'b000101);
  endfunction

  // Cycles per instruction, taken from the instruction-class table.
  function automatic int cpi(input logic [5:0] op);
    if (!legal(op))      return 2;
    case (op)
      6'b100011: return 5;
      6'b000100, 6'b000101, 6'b000010: return 3;
      default:   return 4;
    endcase
  endfunction

  // Reference model: gives the expected state and control word for step n of an instruction.
  task automatic model(input logic [5:0] op, input int n, input logic z,
                       output logic [3:0] st, output ctrl_t c);
    c = '0;
    st = 4'd0;
    if (n == 0) begin
      c.irwrite = 1'b1; c.srcb = 2'b01; c.pcen = 1'b1;
    end else if (n == 1) begin
      st = 4'd1; c.srcb = 2'b11; c.illegal = !legal(op);
    end else if (op == 6'b100011 || op == 6'b101011) begin
      if (n == 2) begin st = 4'd2; c.srca = 1'b1; c.srcb = 2'b10; end
      else if (op == 6'b101011) begin st = 4'd5; c.iord = 1'b1; c.memwrite = 1'b1; end
      else if (n == 3) begin st = 4'd3; c.iord = 1'b1; end
      else begin st = 4'd4; c.memtoreg = 1'b1; c.regwrite = 1'b1; end
    end else if (op == 6'b000000) begin
      if (n == 2) begin st = 4'd6; c.srca = 1'b1; c.aluop = 2'b10; end
      else begin st = 4'd7; c.regdst = 1'b1; c.regwrite = 1'b1; end
    end else if (op == 6'b000100 || op == 6'b000101) begin
      st = 4'd8; c.srca = 1'b1; c.aluop = 2'b01; c.pcsrc = 2'b01;
      c.pcen = (op == 6'b000101) ? ~z : z;
    end else if (op == 6'b001000) begin
      if (n == 2) begin st = 4'd9; c.srca = 1'b1; c.srcb = 2'b10; end
      else begin st = 4'd10; c.regwrite = 1'b1; end
    end else begin
      st = 4'd11; c.pcsrc = 2'b10; c.pcen = 1'b1;
    end
  endtask

  // Runs one instruction starting from FETCH.
  // zmode 0 or 1 forces zero_i; 2 randomizes it every cycle.
  // abort_at >= 0 stops just before that step.
  task automatic run_instr(input logic [5:0] op, input int zmode, input int abort_at);
    logic [3:0] est;
    ctrl_t      ec;
    for (int n = 0; n < cpi(op); n++) begin
      if (n == abort_at) return;
      opcode_i = op;
      zero_i = (zmode == 2) ? 1'($urandom_range(0, 1)) : 1'(zmode);
      #3;
      model(op, n, zero_i, est, ec);
      chk($sformatf("state op=%b step%0d", op, n), 32'(state_o), 32'(est));
      chk($sformatf("ctrl op=%b step%0d", op, n), 32'(observed()), 32'(ec));
      chk("regwrite_memwrite_exclusive", 32'(RegWrite_o & MemWrite_o), 32'd0);
      @(posedge clk);
      #1;
    end
  endtask

  // Checks the outputs held while reset is low: the FETCH selects with every write enable off.
  task automatic chk_in_reset(input string tag);
    ctrl_t ec;
    ec = '0;
    ec.srcb = 2'b01;
    chk({tag, " state"}, 32'(state_o), 32'd0);
    chk({tag, " ctrl"}, 32'(observed()), 32'(ec));
  endtask

  initial begin
    logic [5:0] op;
    reset = 1'b0;
    opcode_i = 6'b000000;
    zero_i = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    chk_in_reset("reset_initial");
    reset = 1'b1;

    // Directed instructions.
    run_instr(6'b100011, 2, -1);  // lw
    run_instr(6'b000000, 2, -1);  // R-type
    run_instr(6'b101011, 2, -1);  // sw
    run_instr(6'b000100, 1, -1);  // beq taken
    run_instr(6'b000100, 0, -1);  // beq not taken
    run_instr(6'b000010, 2, -1);  // j
    run_instr(6'b111111, 2, -1);  // illegal
    run_instr(6'b001000, 2, -1);  // addi
    run_instr(6'b000101, 0, -1);  // bne (illegal unless enabled)
    run_instr(6'b000101, 1, -1);

    // Reset asserted mid-MEMWB and held for 3 cycles.
    run_instr(6'b100011, 2, 4);
    chk("pre_abort_state", 32'(state_o), 32'd4);
    reset = 1'b0;
    #1;
    chk_in_reset("reset_abort_c0");
    for (int i = 1; i < 3; i++) begin
      @(posedge clk);
      #1;
      chk_in_reset($sformatf("reset_abort_c%0d", i));
    end
    @(posedge clk);
    #1;
    reset = 1'b1;
    run_instr(6'b000000, 2, -1);  // FETCH again right after release

    // Random opcodes, biased toward the known ones.
    for (int i = 0; i < 60; i++) begin
      case ($urandom_range(0, 7))
        0: op = 6'b100011;
        1: op = 6'b101011;
        2: op = 6'b000000;
        3: op = 6'b000100;
        4: op = 6'b001000;
        5: op = 6'b000010;
        6: op = 6'b000101;
        default: op = 6'($urandom_range(0, 63));
      endcase
      run_instr(op, 2, -1);
    end
    #3;
    chk("final_state_fetch", 32'(state_o), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
